pipe_accum_adder_tree: RTL and testbench

- Pipelined signed adder tree that reduces ELEMENTS signed lanes to one sum per beat.
- An accumulator stage sums tree results across beats until `in_last`, so dot-product rows can be longer than the vector width.
- Sits after the elementwise multipliers in the MAC datapath and feeds the activation/requantise stage.
- Successor to the fixed 8-lane tree. Adds arbitrary lane count, width growth, valid/last framing, multi-beat accumulation and synchronous reset.

---
 rtl/pipe_accum_adder_tree.sv | 117 +++++++++++
 tb/tb_pipe_accum_adder_tree.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_accum_adder_tree.sv
// Pipelined signed adder tree with multi-beat row accumulation and sticky overflow.
// Optional macro ACCUM_SATURATE_EN: clamp the accumulator on overflow instead of wrapping.
module pipe_accum_adder_tree #(
    parameter int ELEMENTS  = 8,
    parameter int IN_WIDTH  = 10,
    parameter int ACC_WIDTH = 24
) (
    input  logic                                      clk_in,
    input  logic                                      rst_in,
    input  logic signed [ELEMENTS-1:0][IN_WIDTH-1:0]  in,
    input  logic                                      in_valid,
    input  logic                                      in_last,
    output logic signed [ACC_WIDTH-1:0]               out,
    output logic                                      out_valid,
    output logic                                      overflow
);

    localparam int LEVELS = $clog2(ELEMENTS);
    localparam int TREE_W = IN_WIDTH + LEVELS;
    localparam int SUM_W  = ACC_WIDTH + 1;

    function automatic int lanes_at(input int k);
        return (ELEMENTS + (1 << k) - 1) >> k;
    endfunction

    // Every level is exported sign-extended to TREE_W so the next level can index it uniformly.
    logic signed [TREE_W-1:0] lvl [LEVELS+1][ELEMENTS];

    for (genvar j = 0; j < ELEMENTS; j++) begin : g_in
        assign lvl[0][j] = TREE_W'($signed(in[j]));
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int N  = lanes_at(k);
        localparam int NP = lanes_at(k - 1);
        localparam int W  = IN_WIDTH + k;
        for (genvar j = 0; j < ELEMENTS; j++) begin : g_lane
            if (j < N) begin : g_reg
                logic signed [W-1:0] q;
                if (2 * j + 1 < NP) begin : g_pair
                    always_ff @(posedge clk_in) begin
                        if (rst_in) q <= '0;
                        else        q <= W'(lvl[k-1][2*j] + lvl[k-1][2*j+1]);
                    end
                end else begin : g_pass
                    always_ff @(posedge clk_in) begin
                        if (rst_in) q <= '0;
                        else        q <= W'(lvl[k-1][2*j]);
                    end
                end
                assign lvl[k][j] = TREE_W'(q);
            end else begin : g_none
                assign lvl[k][j] = '0;
            end
        end
    end

    logic [LEVELS-1:0] vld_pipe;
    logic [LEVELS-1:0] last_pipe;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[0]  <= in_valid;
            last_pipe[0] <= in_valid & in_last;
            for (int i = 1; i < LEVELS; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] tree_ext;
    logic signed [ACC_WIDTH-1:0] sum_res;
    logic signed [SUM_W-1:0]     sum_full;
    logic                        sum_ovf;

    assign tree_ext = ACC_WIDTH'(lvl[LEVELS][0]);

    // One guard bit makes overflow a disagreement between the top two sum bits.
    always_comb begin
        sum_full = SUM_W'(acc) + SUM_W'(tree_ext);
        sum_ovf  = sum_full[ACC_WIDTH] ^ sum_full[ACC_WIDTH-1];
`ifdef ACCUM_SATURATE_EN
        if (sum_ovf) sum_res = sum_full[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else         sum_res = sum_full[ACC_WIDTH-1:0];
`else
        sum_res = sum_full[ACC_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (vld_pipe[LEVELS-1]) begin
                if (sum_ovf) overflow <= 1'b1;
                if (last_pipe[LEVELS-1]) begin
                    out       <= sum_res;
                    out_valid <= 1'b1;
                    acc       <= '0;
                end else begin
                    acc <= sum_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_accum_adder_tree.sv
// Randomized scoreboard bench for pipe_accum_adder_tree plus directed checks on odd-lane and narrow builds.
module tb_pipe_accum_adder_tree;

    localparam int E  = 8;
    localparam int IW = 10;
    localparam int AW = 24;
    localparam int LV = 3;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic rst_in;
    int   cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    logic signed [E-1:0][IW-1:0] in_m;
    logic                        v_m, l_m;
    logic signed [AW-1:0]        out_m;
    logic                        ov_m, of_m;

    logic signed [6:0][IW-1:0]   in7;
    logic                        v7, l7;
    logic signed [AW-1:0]        out7;
    logic                        ov7, of7;

    logic signed [4:0][IW-1:0]   in5;
    logic                        v5, l5;
    logic signed [AW-1:0]        out5;
    logic                        ov5, of5;

    logic signed [E-1:0][IW-1:0] in14;
    logic                        v14, l14;
    logic signed [13:0]          out14;
    logic                        ov14, of14;

    pipe_accum_adder_tree #(.ELEMENTS(E), .IN_WIDTH(IW), .ACC_WIDTH(AW)) u_main (
        .clk_in(clk_in), .rst_in(rst_in), .in(in_m), .in_valid(v_m), .in_last(l_m),
        .out(out_m), .out_valid(ov_m), .overflow(of_m));

    pipe_accum_adder_tree #(.ELEMENTS(7), .IN_WIDTH(IW), .ACC_WIDTH(AW)) u_e7 (
        .clk_in(clk_in), .rst_in(rst_in), .in(in7), .in_valid(v7), .in_last(l7),
        .out(out7), .out_valid(ov7), .overflow(of7));

    pipe_accum_adder_tree #(.ELEMENTS(5), .IN_WIDTH(IW), .ACC_WIDTH(AW)) u_e5 (
        .clk_in(clk_in), .rst_in(rst_in), .in(in5), .in_valid(v5), .in_last(l5),
        .out(out5), .out_valid(ov5), .overflow(of5));

    pipe_accum_adder_tree #(.ELEMENTS(E), .IN_WIDTH(IW), .ACC_WIDTH(14)) u_w14 (
        .clk_in(clk_in), .rst_in(rst_in), .in(in14), .in_valid(v14), .in_last(l14),
        .out(out14), .out_valid(ov14), .overflow(of14));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        longint val;
        int     due;
    } exp_t;
    exp_t   sb[$];
    longint row_acc;
    bit     exp_ovf;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Row arithmetic from first principles: add, detect out-of-range, then wrap or clamp.
    function automatic longint acc_add(input longint a, input longint b, input int w, inout bit ov);
        longint s  = a + b;
        longint mx = (64'sd1 <<< (w - 1)) - 1;
        longint mn = -mx - 1;
        if (s > mx || s < mn) begin
            ov = 1'b1;
`ifdef ACCUM_SATURATE_EN
            s = (s > mx) ? mx : mn;
`else
            s = (s > mx) ? s - (64'sd1 <<< w) : s + (64'sd1 <<< w);
`endif
        end
        return s;
    endfunction

    task automatic send_m(input int lanes[E], input bit last, input bit push);
        int     c;
        longint bsum = 0;
        for (int j = 0; j < E; j++) begin
            in_m[j] = IW'(lanes[j]);
            bsum += lanes[j];
        end
        v_m = 1'b1;
        l_m = last;
        c   = cyc;
        @(posedge clk_in);
        #1;
        v_m = 1'b0;
        l_m = 1'($urandom_range(0, 1));
        row_acc = acc_add(row_acc, bsum, AW, exp_ovf);
        if (last) begin
            if (push) sb.push_back('{row_acc, c + LV + 1});
            row_acc = 0;
        end
    endtask

    task automatic idle_m(input int n);
        repeat (n) begin
            v_m = 1'b0;
            l_m = 1'($urandom_range(0, 1));
            @(posedge clk_in);
            #1;
        end
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (!rst_in && ov_m) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got out_valid=1 out=%0d expected no pulse (cycle %0d)", out_m, cyc);
            end else begin
                e = sb.pop_front();
                check("row_sum", out_m, e.val);
                check("row_latency", cyc, e.due);
            end
        end
    end

    initial begin
        int     c, p7, p5, p14, t7, t5, t14;
        longint o7, o5, o14, s14;
        bit     ovf14;
        int     ones[E], negs[E], rl[E];
        int     nb;

        rst_in = 1'b1;
        in_m = '0; v_m = 0; l_m = 0;
        in7  = '0; v7  = 0; l7  = 0;
        in5  = '0; v5  = 0; l5  = 0;
        in14 = '0; v14 = 0; l14 = 0;
        row_acc = 0;
        exp_ovf = 0;
        for (int j = 0; j < E; j++) begin
            ones[j] = 1;
            negs[j] = -512;
        end
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("reset_out", out_m, 0);
        check("reset_out_valid", ov_m, 0);
        check("reset_overflow", of_m, 0);
        check("reset_out_w14", out14, 0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // Directed: 7 lanes, 5 odd lanes, and a 14-bit accumulator over 3 beats.
        for (int j = 0; j < 7; j++) in7[j] = IW'(1);
        in5[0] = IW'(3); in5[1] = IW'(-1); in5[2] = IW'(2); in5[3] = IW'(-4); in5[4] = IW'(5);
        for (int j = 0; j < E; j++) in14[j] = IW'(511);
        v7 = 1; l7 = 1; v5 = 1; l5 = 1; v14 = 1; l14 = 0;
        c = cyc;
        @(posedge clk_in); #1;
        v7 = 0; l7 = 0; v5 = 0; l5 = 0;
        @(posedge clk_in); #1;
        l14 = 1;
        @(posedge clk_in); #1;
        v14 = 0; l14 = 0;
        p7 = 0; p5 = 0; p14 = 0; t7 = 0; t5 = 0; t14 = 0; o7 = 0; o5 = 0; o14 = 0;
        repeat (12) begin
            @(negedge clk_in);
            if (ov7)  begin p7++;  t7  = cyc; o7  = out7;  end
            if (ov5)  begin p5++;  t5  = cyc; o5  = out5;  end
            if (ov14) begin p14++; t14 = cyc; o14 = out14; end
        end
        check("e7_pulses", p7, 1);
        check("e7_latency", t7, c + 4);
        check("e7_sum", o7, 7);
        check("e5_pulses", p5, 1);
        check("e5_latency", t5, c + 4);
        check("e5_sum", o5, 5);
        s14 = 0;
        ovf14 = 0;
        repeat (3) s14 = acc_add(s14, 8 * 511, 14, ovf14);
        check("w14_pulses", p14, 1);
        check("w14_latency", t14, c + 6);
        check("w14_sum", o14, s14);
        check("w14_overflow", of14, longint'(ovf14));

        // Three-beat row with a gap, then back-to-back single-beat minimum rows.
        send_m(ones, 0, 1);
        idle_m(1);
        send_m(ones, 0, 1);
        send_m(ones, 1, 1);
        repeat (4) send_m(negs, 1, 1);
        idle_m(2);

        for (int r = 0; r < 40; r++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                for (int j = 0; j < E; j++) rl[j] = int'($urandom_range(0, 1023)) - 512;
                send_m(rl, b == nb - 1, 1);
                if ($urandom_range(0, 3) == 0) idle_m($urandom_range(1, 2));
            end
        end
        idle_m(LV + 3);

        // Reset while a two-beat row is still inside the tree.
        send_m(ones, 0, 0);
        send_m(ones, 1, 0);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        check("midreset_out", out_m, 0);
        check("midreset_out_valid", ov_m, 0);
        rst_in  = 1'b0;
        row_acc = 0;
        exp_ovf = 0;
        send_m(ones, 1, 1);
        idle_m(LV + 4);

        check("queue_drained", sb.size(), 0);
        check("overflow_main", of_m, longint'(exp_ovf));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
